// File: rtl/dest_sel_pipe_pkg.sv
// Datapath package: destination-select encodings, default register codes,
// the {valid, dest} stage entry type and a select-legality helper.
package dest_sel_pipe_pkg;

  localparam int REG_W_DEF = 4;

  // Destination select encodings; 5..7 are illegal.
  localparam logic [2:0] DSEL_RD0  = 3'd0;
  localparam logic [2:0] DSEL_LINK = 3'd1;
  localparam logic [2:0] DSEL_RD2  = 3'd2;
  localparam logic [2:0] DSEL_ALT  = 3'd3;
  localparam logic [2:0] DSEL_RD4  = 3'd4;

  // Default fixed register codes.
  localparam logic [REG_W_DEF-1:0] LINK_REG_DEF = 4'd15;
  localparam logic [REG_W_DEF-1:0] ALT_REG_DEF  = 4'd14;

  // Pipeline stage entry at the default register width.
  typedef struct packed {
    logic                 valid;
    logic [REG_W_DEF-1:0] dest;
  } dest_entry_t;

  function automatic logic sel_legal(input logic [2:0] s);
    return (s <= DSEL_RD4);
  endfunction

endpackage

// File: rtl/dest_sel_pipe_decode.sv
// Combinational destination-select decode with legality flag.
// Illegal selects yield dest = 0 and legal = 0.
module dest_sel_pipe_decode
  import dest_sel_pipe_pkg::*;
#(
  parameter int               REG_W    = 4,
  parameter logic [REG_W-1:0] LINK_REG = REG_W'(LINK_REG_DEF),
  parameter logic [REG_W-1:0] ALT_REG  = REG_W'(ALT_REG_DEF)
) (
  input  logic [2:0]       sel,
  input  logic [REG_W-1:0] data0,
  input  logic [REG_W-1:0] data2,
  input  logic [REG_W-1:0] data4,
  output logic [REG_W-1:0] dest,
  output logic             legal
);

  // Select mux; default covers the illegal codes.
  always_comb begin
    dest  = '0;
    legal = sel_legal(sel);
    case (sel)
      DSEL_RD0:  dest = data0;
      DSEL_LINK: dest = LINK_REG;
      DSEL_RD2:  dest = data2;
      DSEL_ALT:  dest = ALT_REG;
      DSEL_RD4:  dest = data4;
      default:   dest = '0;
    endcase
  end

endmodule

// File: rtl/dest_sel_pipe.sv
// Destination-register select pipeline: decodes the write-back destination,
// carries {valid, dest} through STAGES registers with stall/flush control,
// and exposes RAW hazard flags, a pending-write count and the register-file
// write port.
//
// Control semantics: an instruction is captured on an edge where stall=0 and
// flush=0; in_valid qualifies the capture. Stall holds every stage and drops
// the inputs for that cycle. Flush outranks stall and clears all valids, but
// the final-stage entry still writes back in the flush cycle. Reset outranks
// both.
module dest_sel_pipe
  import dest_sel_pipe_pkg::*;
#(
  parameter int               REG_W    = 4,
  parameter int               STAGES   = 3,
  parameter logic [REG_W-1:0] LINK_REG = REG_W'(LINK_REG_DEF),
  parameter logic [REG_W-1:0] ALT_REG  = REG_W'(ALT_REG_DEF)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:0]                  sel,
  input  logic [REG_W-1:0]            data0,
  input  logic [REG_W-1:0]            data2,
  input  logic [REG_W-1:0]            data4,
  input  logic                        in_valid,
  input  logic                        wr_en_in,
  input  logic                        stall,
  input  logic                        flush,
  input  logic [REG_W-1:0]            src_a,
  input  logic [REG_W-1:0]            src_b,
  output logic                        hazard_a,
  output logic                        hazard_b,
  output logic [REG_W-1:0]            wb_dest,
  output logic                        wb_we,
  output logic [$clog2(STAGES+1)-1:0] pending_cnt,
  output logic                        sel_err
);

  localparam int CNT_W = $clog2(STAGES + 1);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
  } stage_t;

  stage_t           pipe_q [STAGES];
  logic [REG_W-1:0] dec_dest;
  logic             dec_legal;
  logic             sel_err_q;
  logic             capture;

  dest_sel_pipe_decode #(
    .REG_W    (REG_W),
    .LINK_REG (LINK_REG),
    .ALT_REG  (ALT_REG)
  ) u_decode (
    .sel   (sel),
    .data0 (data0),
    .data2 (data2),
    .data4 (data4),
    .dest  (dec_dest),
    .legal (dec_legal)
  );

  assign capture = !stall && !flush;

  // Pipeline registers plus the registered illegal-select pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        pipe_q[k] <= '0;
      end
      sel_err_q <= 1'b0;
    end else if (flush) begin
      // Dests keep stale values; only the valids matter after a flush.
      for (int k = 0; k < STAGES; k++) begin
        pipe_q[k].valid <= 1'b0;
      end
      sel_err_q <= 1'b0;
    end else if (capture) begin
      pipe_q[0].valid <= in_valid & wr_en_in & dec_legal;
      pipe_q[0].dest  <= dec_dest;
      for (int k = 1; k < STAGES; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
      sel_err_q <= in_valid & ~dec_legal;
    end else begin
      sel_err_q <= 1'b0;
    end
  end

  assign sel_err = sel_err_q;
  assign wb_dest = pipe_q[STAGES-1].dest;
  // A stalled final stage writes only when it finally advances (or is flushed).
  assign wb_we   = pipe_q[STAGES-1].valid & (!stall | flush);

  // Hazard compares and valid popcount over all stages.
  always_comb begin
    hazard_a    = 1'b0;
    hazard_b    = 1'b0;
    pending_cnt = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (pipe_q[k].valid && (pipe_q[k].dest == src_a)) hazard_a = 1'b1;
      if (pipe_q[k].valid && (pipe_q[k].dest == src_b)) hazard_b = 1'b1;
      pending_cnt = pending_cnt + CNT_W'(pipe_q[k].valid);
    end
  end

endmodule

// File: tb/tb_dest_sel_pipe.sv
// Self-checking bench for dest_sel_pipe (STAGES=3, 4-bit registers).
module tb_dest_sel_pipe;

  logic       clk;
  logic       reset;
  logic [2:0] sel;
  logic [3:0] data0, data2, data4;
  logic       in_valid, wr_en_in, stall, flush;
  logic [3:0] src_a, src_b;
  logic       hazard_a, hazard_b;
  logic [3:0] wb_dest;
  logic       wb_we;
  logic [1:0] pending_cnt;
  logic       sel_err;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  logic       err_prev;

  dest_sel_pipe #(
    .REG_W    (4),
    .STAGES   (3),
    .LINK_REG (4'd15),
    .ALT_REG  (4'd14)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sel         (sel),
    .data0       (data0),
    .data2       (data2),
    .data4       (data4),
    .in_valid    (in_valid),
    .wr_en_in    (wr_en_in),
    .stall       (stall),
    .flush       (flush),
    .src_a       (src_a),
    .src_b       (src_b),
    .hazard_a    (hazard_a),
    .hazard_b    (hazard_b),
    .wb_dest     (wb_dest),
    .wb_we       (wb_we),
    .pending_cnt (pending_cnt),
    .sel_err     (sel_err)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode: 15 for link, 14 for alternate, 0 when illegal.
  function automatic logic [3:0] model_dest(input logic [2:0] s, input logic [3:0] d0,
                                            input logic [3:0] d2, input logic [3:0] d4);
    case (s)
      3'd0:    return d0;
      3'd1:    return 4'd15;
      3'd2:    return d2;
      3'd3:    return 4'd14;
      3'd4:    return d4;
      default: return 4'd0;
    endcase
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    wr_en_in = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    sel      = 3'd0;
  endtask

  // Drive one writing instruction; the selected candidate gets d, the
  // others get random values. Expected write-back goes to the scoreboard.
  task automatic issue(input logic [2:0] s, input logic [3:0] d);
    data0 = 4'($urandom_range(0, 15));
    data2 = 4'($urandom_range(0, 15));
    data4 = 4'($urandom_range(0, 15));
    if (s == 3'd0) data0 = d;
    if (s == 3'd2) data2 = d;
    if (s == 3'd4) data4 = d;
    sel      = s;
    in_valid = 1'b1;
    wr_en_in = 1'b1;
    stall    = 1'b0;
    flush    = 1'b0;
    if (s <= 3'd4) exp_q.push_back(model_dest(s, data0, data2, data4));
  endtask

  // Scoreboard consumer: every write-back must match the oldest expected dest.
  always @(negedge clk) begin
    if (wb_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", {28'd0, wb_dest}, 32'hFFFF_FFFF);
      end else begin
        chk("wb_dest_sb", {28'd0, wb_dest}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    reset = 1'b1;
    src_a = 4'd0;
    src_b = 4'd0;
    data0 = 4'd0;
    data2 = 4'd0;
    data4 = 4'd0;
    idle();

    // Reset state
    nxt();
    nxt();
    settle();
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_wb_dest", 32'(wb_dest), 32'd0);
    chk("rst_pending", 32'(pending_cnt), 32'd0);
    chk("rst_hazard_a", 32'(hazard_a), 32'd0);
    chk("rst_hazard_b", 32'(hazard_b), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    reset = 1'b0;
    nxt();

    // Single link-register instruction: write-back 3 cycles later, once
    issue(3'd1, 4'd0);
    nxt();
    idle();
    settle();
    chk("lat_pend1", 32'(pending_cnt), 32'd1);
    chk("lat_we1", 32'(wb_we), 32'd0);
    nxt();
    settle();
    chk("lat_pend2", 32'(pending_cnt), 32'd1);
    chk("lat_we2", 32'(wb_we), 32'd0);
    nxt();
    settle();
    chk("lat_pend3", 32'(pending_cnt), 32'd1);
    chk("lat_we3", 32'(wb_we), 32'd1);
    chk("lat_dest3", 32'(wb_dest), 32'd15);
    nxt();
    settle();
    chk("lat_pend4", 32'(pending_cnt), 32'd0);
    chk("lat_we4", 32'(wb_we), 32'd0);

    // Back-to-back 3, 7, 14 with hazard tracking
    src_a = 4'd7;
    src_b = 4'd3;
    issue(3'd0, 4'd3);
    nxt();
    issue(3'd2, 4'd7);
    settle();
    chk("b2b_haz_b0", 32'(hazard_b), 32'd1);
    chk("b2b_haz_a0", 32'(hazard_a), 32'd0);
    nxt();
    issue(3'd3, 4'd0);
    settle();
    chk("b2b_haz_a1", 32'(hazard_a), 32'd1);
    nxt();
    idle();
    settle();
    chk("b2b_we_a", 32'(wb_we), 32'd1);
    chk("b2b_dest_a", 32'(wb_dest), 32'd3);
    chk("b2b_haz_a2", 32'(hazard_a), 32'd1);
    chk("b2b_pend", 32'(pending_cnt), 32'd3);
    nxt();
    settle();
    chk("b2b_dest_b", 32'(wb_dest), 32'd7);
    chk("b2b_haz_b1", 32'(hazard_b), 32'd0);
    nxt();
    settle();
    chk("b2b_dest_c", 32'(wb_dest), 32'd14);
    chk("b2b_haz_a3", 32'(hazard_a), 32'd0);
    nxt();
    settle();
    chk("b2b_drained", 32'(pending_cnt), 32'd0);

    // Stall two cycles with the entry in the final stage
    issue(3'd4, 4'd9);
    nxt();
    idle();
    nxt();
    nxt();
    stall    = 1'b1;
    in_valid = 1'b1;
    wr_en_in = 1'b1;
    sel      = 3'd0;
    data0    = 4'd2;
    settle();
    chk("stall_we1", 32'(wb_we), 32'd0);
    chk("stall_dest1", 32'(wb_dest), 32'd9);
    nxt();
    settle();
    chk("stall_we2", 32'(wb_we), 32'd0);
    chk("stall_pend", 32'(pending_cnt), 32'd1);
    nxt();
    idle();
    settle();
    chk("stall_rel_we", 32'(wb_we), 32'd1);
    chk("stall_rel_dest", 32'(wb_dest), 32'd9);
    nxt();
    settle();
    chk("stall_after_we", 32'(wb_we), 32'd0);
    chk("stall_after_pend", 32'(pending_cnt), 32'd0);

    // Flush with stall while three entries are in flight
    issue(3'd0, 4'd1);
    nxt();
    issue(3'd0, 4'd2);
    nxt();
    issue(3'd0, 4'd5);
    nxt();
    idle();
    flush = 1'b1;
    stall = 1'b1;
    src_a = 4'd2;
    src_b = 4'd5;
    settle();
    chk("fl_we", 32'(wb_we), 32'd1);
    chk("fl_dest", 32'(wb_dest), 32'd1);
    chk("fl_pend", 32'(pending_cnt), 32'd3);
    chk("fl_haz_a", 32'(hazard_a), 32'd1);
    chk("fl_haz_b", 32'(hazard_b), 32'd1);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    nxt();
    idle();
    settle();
    chk("fl_after_pend", 32'(pending_cnt), 32'd0);
    chk("fl_after_haz_a", 32'(hazard_a), 32'd0);
    chk("fl_after_haz_b", 32'(hazard_b), 32'd0);
    chk("fl_after_we", 32'(wb_we), 32'd0);

    // Illegal select: one-cycle sel_err pulse, no write-back
    issue(3'd6, 4'd0);
    nxt();
    idle();
    settle();
    chk("ill_err1", 32'(sel_err), 32'd1);
    chk("ill_pend", 32'(pending_cnt), 32'd0);
    nxt();
    settle();
    chk("ill_err2", 32'(sel_err), 32'd0);
    nxt();
    settle();
    chk("ill_we", 32'(wb_we), 32'd0);
    // Illegal select without in_valid raises no error
    sel      = 3'd7;
    in_valid = 1'b0;
    nxt();
    idle();
    settle();
    chk("ill_noval_err", 32'(sel_err), 32'd0);

    // Reset mid-pipeline with two valid entries
    issue(3'd1, 4'd0);
    nxt();
    issue(3'd3, 4'd0);
    nxt();
    idle();
    src_a = 4'd15;
    src_b = 4'd14;
    settle();
    chk("mr_pend_pre", 32'(pending_cnt), 32'd2);
    chk("mr_haz_a_pre", 32'(hazard_a), 32'd1);
    reset = 1'b1;
    nxt();
    settle();
    exp_q.delete();
    chk("mr_pend", 32'(pending_cnt), 32'd0);
    chk("mr_we", 32'(wb_we), 32'd0);
    chk("mr_dest", 32'(wb_dest), 32'd0);
    chk("mr_haz_a", 32'(hazard_a), 32'd0);
    chk("mr_haz_b", 32'(hazard_b), 32'd0);
    reset = 1'b0;
    nxt();

    // Random traffic, no stall/flush; scoreboard checks the write-back order
    err_prev = 1'b0;
    for (int i = 0; i < 30; i++) begin
      sel      = 3'($urandom_range(0, 7));
      data0    = 4'($urandom_range(0, 15));
      data2    = 4'($urandom_range(0, 15));
      data4    = 4'($urandom_range(0, 15));
      in_valid = 1'($urandom_range(0, 1));
      wr_en_in = 1'($urandom_range(0, 1));
      stall    = 1'b0;
      flush    = 1'b0;
      settle();
      chk("rnd_sel_err", 32'(sel_err), 32'(err_prev));
      err_prev = in_valid && (sel > 3'd4);
      if (in_valid && wr_en_in && (sel <= 3'd4))
        exp_q.push_back(model_dest(sel, data0, data2, data4));
      nxt();
    end
    idle();
    settle();
    chk("rnd_sel_err_last", 32'(sel_err), 32'(err_prev));
    repeat (4) nxt();
    settle();
    chk("end_pend", 32'(pending_cnt), 32'd0);
    chk("end_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
